// File: rtl/clock_pkg.sv
// Shared encodings, field limits and wrap helpers for the time-set controller.
package clock_pkg;

  localparam int HR_W = 5;
  localparam int MS_W = 6;

  localparam logic [HR_W-1:0] HR_MAX  = 5'd23;
  localparam logic [MS_W-1:0] MIN_MAX = 6'd59;
  localparam logic [MS_W-1:0] SEC_MAX = 6'd59;

  localparam logic [2:0] ST_NORMAL  = 3'd0;
  localparam logic [2:0] ST_SET_HR  = 3'd1;
  localparam logic [2:0] ST_SET_MIN = 3'd2;
  localparam logic [2:0] ST_SET_SEC = 3'd3;
  localparam logic [2:0] ST_COMMIT  = 3'd4;

  typedef enum logic [2:0] {
    NORMAL  = ST_NORMAL,
    SET_HR  = ST_SET_HR,
    SET_MIN = ST_SET_MIN,
    SET_SEC = ST_SET_SEC,
    COMMIT  = ST_COMMIT
  } state_t;

  localparam logic [1:0] FS_NONE = 2'b00;
  localparam logic [1:0] FS_HR   = 2'b01;
  localparam logic [1:0] FS_MIN  = 2'b10;
  localparam logic [1:0] FS_SEC  = 2'b11;

  // Anything at or above the limit (including garbage captured values) wraps to 0.
  function automatic logic [HR_W-1:0] inc_hr(input logic [HR_W-1:0] v);
    return (v >= HR_MAX) ? '0 : v + HR_W'(1);
  endfunction

  function automatic logic [MS_W-1:0] inc_ms(input logic [MS_W-1:0] v, input logic [MS_W-1:0] max);
    return (v >= max) ? '0 : v + MS_W'(1);
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button/time inputs and edited-time/display outputs of the time-set controller.
interface time_set_ctrl_if;
  import clock_pkg::*;

  logic            tick;
  logic            mode_btn;
  logic            inc_btn;
  logic [HR_W-1:0] cur_hr;
  logic [MS_W-1:0] cur_min;
  logic [MS_W-1:0] cur_sec;
  logic [HR_W-1:0] set_hr;
  logic [MS_W-1:0] set_min;
  logic [MS_W-1:0] set_sec;
  logic            load;
  logic            edit_active;
  logic [1:0]      field_sel;
  logic [2:0]      blink_mask;

  modport master (
    input  tick, mode_btn, inc_btn, cur_hr, cur_min, cur_sec,
    output set_hr, set_min, set_sec, load, edit_active, field_sel, blink_mask
  );

  modport slave (
    output tick, mode_btn, inc_btn, cur_hr, cur_min, cur_sec,
    input  set_hr, set_min, set_sec, load, edit_active, field_sel, blink_mask
  );

endinterface

// File: rtl/key_repeat.sv
// Turns the held increment key into single-cycle pulses: one on the press edge and,
// with AUTO_REPEAT_EN defined, tick-timed repeats while held (clr restarts the delay).
module key_repeat #(
  parameter int REPEAT_DELAY = 5,
  parameter int REPEAT_RATE  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key,
  input  logic clr,
  output logic inc_pulse
);

  logic key_q;
  logic key_rise;

  always_ff @(posedge clk) begin
    if (rst) key_q <= 1'b0;
    else     key_q <= key;
  end

  assign key_rise = key & ~key_q;

`ifdef AUTO_REPEAT_EN
  localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [CNT_W-1:0] rpt_cnt;
  logic [CNT_W-1:0] rpt_cnt_inc;
  logic             rpt_hit;

  assign rpt_cnt_inc = rpt_cnt + CNT_W'(1);
  assign rpt_hit     = key & tick & (rpt_cnt_inc == DELAY_C);

  // After the first repeat the counter reloads so later hits land every REPEAT_RATE ticks.
  always_ff @(posedge clk) begin
    if (rst || clr || !key) rpt_cnt <= '0;
    else if (tick)          rpt_cnt <= rpt_hit ? RELOAD_C : rpt_cnt_inc;
  end

  assign inc_pulse = key_rise | rpt_hit;
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_RATE, tick, clr};
  assign inc_pulse      = key_rise;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set editor: captures running time, edits hr/min/sec with wrap, strobes load on commit.
// Optional AUTO_REPEAT_EN enables held-key auto-repeat inside key_repeat.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 100,
  parameter int REPEAT_DELAY  = 5,
  parameter int REPEAT_RATE   = 2
) (
  input  logic           clk,
  input  logic           rst,
  time_set_ctrl_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS);

  state_t          state, state_nxt;
  logic            editing, inc_pulse, rpt_clr, to_hit;
  logic [TO_W-1:0] to_cnt, to_cnt_inc;
  logic [1:0]      fs_nxt;
  logic [2:0]      blink_nxt;

  assign editing = state inside {SET_HR, SET_MIN, SET_SEC};
  assign rpt_clr = bus.mode_btn | ~editing;

  key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_key_repeat (
    .clk       (clk),
    .rst       (rst),
    .tick      (bus.tick),
    .key       (bus.inc_btn),
    .clr       (rpt_clr),
    .inc_pulse (inc_pulse)
  );

  assign to_cnt_inc = to_cnt + TO_W'(1);
  assign to_hit     = editing & bus.tick & ~inc_pulse & (to_cnt_inc == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst || !editing || bus.mode_btn || inc_pulse) to_cnt <= '0;
    else if (bus.tick)                                to_cnt <= to_cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= NORMAL;
    else     state <= state_nxt;
  end

  // mode_btn outranks timeout expiry in every SET state.
  always_comb begin
    state_nxt = state;
    fs_nxt    = FS_NONE;
    blink_nxt = 3'b000;
    case (state)
      NORMAL:  if (bus.mode_btn) state_nxt = SET_HR;
      SET_HR:  if (bus.mode_btn) state_nxt = SET_MIN; else if (to_hit) state_nxt = NORMAL;
      SET_MIN: if (bus.mode_btn) state_nxt = SET_SEC; else if (to_hit) state_nxt = NORMAL;
      SET_SEC: if (bus.mode_btn) state_nxt = COMMIT;  else if (to_hit) state_nxt = NORMAL;
      COMMIT:  state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
    case (state_nxt)
      SET_HR:  begin fs_nxt = FS_HR;  blink_nxt = 3'b100; end
      SET_MIN: begin fs_nxt = FS_MIN; blink_nxt = 3'b010; end
      SET_SEC: begin fs_nxt = FS_SEC; blink_nxt = 3'b001; end
      default: begin fs_nxt = FS_NONE; blink_nxt = 3'b000; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.set_hr      <= '0;
      bus.set_min     <= '0;
      bus.set_sec     <= '0;
      bus.load        <= 1'b0;
      bus.edit_active <= 1'b0;
      bus.field_sel   <= FS_NONE;
      bus.blink_mask  <= 3'b000;
    end else begin
      bus.load        <= (state_nxt == COMMIT);
      bus.edit_active <= state_nxt inside {SET_HR, SET_MIN, SET_SEC};
      bus.field_sel   <= fs_nxt;
      bus.blink_mask  <= blink_nxt;
      if (state == NORMAL && bus.mode_btn) begin
        bus.set_hr  <= bus.cur_hr;
        bus.set_min <= bus.cur_min;
        bus.set_sec <= bus.cur_sec;
      end else if (inc_pulse && !bus.mode_btn) begin
        case (state)
          SET_HR:  bus.set_hr  <= inc_hr(bus.set_hr);
          SET_MIN: bus.set_min <= inc_ms(bus.set_min, MIN_MAX);
          SET_SEC: bus.set_sec <= inc_ms(bus.set_sec, SEC_MAX);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed vector table, corner sequences and a randomized run vs a reference model.
module tb_time_set_ctrl;

  localparam int TO = 100;
  localparam int RD = 5;
  localparam int RR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  time_set_ctrl_if bus ();

  time_set_ctrl #(.TIMEOUT_TICKS(TO), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  bit load_seen;

  // Reference model: m_fld 0 idle, 1 hr, 2 min, 3 sec, 4 commit.
  int m_fld, m_hr, m_min, m_sec, m_held, m_idle;
  bit m_prev;

  typedef struct {
    bit          mode;
    bit          inc;
    int          hr, mn, sc;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[$];
  int t_hr, t_mn, t_sc;

  function automatic logic [23:0] pack_out(int hr, int mn, int sc, bit ld, bit ed, int fs, int bl);
    return {5'(hr), 6'(mn), 6'(sc), ld, ed, 2'(fs), 3'(bl)};
  endfunction

  function automatic logic [23:0] dut_out();
    return {bus.set_hr, bus.set_min, bus.set_sec, bus.load, bus.edit_active,
            bus.field_sel, bus.blink_mask};
  endfunction

  function automatic logic [23:0] model_out();
    int fs;
    fs = (m_fld >= 1 && m_fld <= 3) ? m_fld : 0;
    return pack_out(m_hr, m_min, m_sec, m_fld == 4, fs != 0, fs, fs != 0 ? (1 << (3 - fs)) : 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit rise, rpt, pulse, in_set;
    if (rst) begin
      m_fld = 0; m_hr = 0; m_min = 0; m_sec = 0;
      m_held = 0; m_idle = 0; m_prev = 0;
      return;
    end
    in_set = (m_fld >= 1 && m_fld <= 3);
    rise   = bus.inc_btn && !m_prev;
    rpt    = 0;
`ifdef AUTO_REPEAT_EN
    if (in_set && !bus.mode_btn && bus.inc_btn) begin
      if (bus.tick) begin
        m_held++;
        rpt = (m_held >= RD) && ((m_held - RD) % RR == 0);
      end
    end else begin
      m_held = 0;
    end
`endif
    pulse  = rise || rpt;
    m_prev = bus.inc_btn;
    if (m_fld == 0) begin
      if (bus.mode_btn) begin
        m_hr = int'(bus.cur_hr); m_min = int'(bus.cur_min); m_sec = int'(bus.cur_sec);
        m_fld = 1; m_idle = 0;
      end
    end else if (m_fld == 4) begin
      m_fld = 0;
    end else if (bus.mode_btn) begin
      m_fld++; m_idle = 0;
    end else if (pulse) begin
      m_idle = 0;
      if (m_fld == 1)      m_hr  = (m_hr  < 23) ? m_hr  + 1 : 0;
      else if (m_fld == 2) m_min = (m_min < 59) ? m_min + 1 : 0;
      else                 m_sec = (m_sec < 59) ? m_sec + 1 : 0;
    end else if (bus.tick) begin
      m_idle++;
      if (m_idle >= TO) begin m_fld = 0; m_idle = 0; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    if (bus.load) load_seen = 1;
    check("model", dut_out(), model_out());
  endtask

  task automatic drive(input bit mode, input bit inc, input bit tk);
    bus.mode_btn = mode; bus.inc_btn = inc; bus.tick = tk;
  endtask

  task automatic set_cur(input int hr, input int mn, input int sc);
    bus.cur_hr = 5'(hr); bus.cur_min = 6'(mn); bus.cur_sec = 6'(sc);
  endtask

  task automatic do_reset();
    drive(0, 0, 0);
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic press_mode();
    bus.mode_btn = 1'b1; step(); bus.mode_btn = 1'b0; step();
  endtask

  task automatic do_tick();
    bus.tick = 1'b1; step(); bus.tick = 1'b0; step(); step();
  endtask

  task automatic add(input bit m, input bit i, input int ehr, input int emn, input int esc,
                     input bit ld, input bit ed, input int fs, input int bl);
    vec_t v;
    v.mode = m; v.inc = i; v.hr = t_hr; v.mn = t_mn; v.sc = t_sc;
    v.exp  = pack_out(ehr, emn, esc, ld, ed, fs, bl);
    vecs.push_back(v);
  endtask

  initial begin
    int gap;
    int exp_min;
    drive(0, 0, 0);
    set_cur(13, 45, 7);
    do_reset();
    check("reset_outputs", dut_out(), 24'h0);
    check("reset_field_sel", bus.field_sel, 2'b00);

    t_hr = 13; t_mn = 45; t_sc = 7;
    add(1, 0, 13, 45, 7, 0, 1, 1, 4);
    add(0, 1, 14, 45, 7, 0, 1, 1, 4);
    add(0, 1, 14, 45, 7, 0, 1, 1, 4);
    add(0, 0, 14, 45, 7, 0, 1, 1, 4);
    add(1, 0, 14, 45, 7, 0, 1, 2, 2);
    add(1, 0, 14, 45, 7, 0, 1, 3, 1);
    add(1, 0, 14, 45, 7, 1, 0, 0, 0);
    add(0, 0, 14, 45, 7, 0, 0, 0, 0);
    add(0, 1, 14, 45, 7, 0, 0, 0, 0);
    add(0, 0, 14, 45, 7, 0, 0, 0, 0);
    t_hr = 23; t_mn = 59; t_sc = 7;
    add(1, 0, 23, 59, 7, 0, 1, 1, 4);
    add(0, 1,  0, 59, 7, 0, 1, 1, 4);
    add(0, 0,  0, 59, 7, 0, 1, 1, 4);
    add(1, 0,  0, 59, 7, 0, 1, 2, 2);
    add(0, 1,  0,  0, 7, 0, 1, 2, 2);
    add(0, 0,  0,  0, 7, 0, 1, 2, 2);
    add(1, 0,  0,  0, 7, 0, 1, 3, 1);
    add(1, 0,  0,  0, 7, 1, 0, 0, 0);
    add(0, 0,  0,  0, 7, 0, 0, 0, 0);
    t_hr = 31; t_mn = 62; t_sc = 59;
    add(1, 0, 31, 62, 59, 0, 1, 1, 4);
    add(0, 1,  0, 62, 59, 0, 1, 1, 4);
    add(0, 0,  0, 62, 59, 0, 1, 1, 4);
    add(1, 0,  0, 62, 59, 0, 1, 2, 2);
    add(0, 1,  0,  0, 59, 0, 1, 2, 2);
    add(0, 0,  0,  0, 59, 0, 1, 2, 2);
    add(1, 0,  0,  0, 59, 0, 1, 3, 1);
    add(0, 1,  0,  0,  0, 0, 1, 3, 1);
    add(0, 0,  0,  0,  0, 0, 1, 3, 1);
    add(1, 0,  0,  0,  0, 1, 0, 0, 0);
    add(0, 0,  0,  0,  0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].mode, vecs[i].inc, 0);
      set_cur(vecs[i].hr, vecs[i].mn, vecs[i].sc);
      step();
      check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end
    drive(0, 0, 0);

    // Auto-repeat: edge plus repeats on held ticks 5,7,9,11.
    do_reset();
    set_cur(0, 10, 0);
    press_mode(); press_mode();
    bus.inc_btn = 1'b1; step();
    check("rpt_edge", bus.set_min, 11);
    repeat (11) do_tick();
`ifdef AUTO_REPEAT_EN
    exp_min = 15;
`else
    exp_min = 11;
`endif
    check("rpt_held", bus.set_min, exp_min);
    bus.inc_btn = 1'b0; step();
    check("rpt_release", bus.set_min, exp_min);
    bus.inc_btn = 1'b1; step();
    repeat (4) do_tick();
    check("rpt_restart", bus.set_min, exp_min + 1);
    check("rpt_still_edit", bus.field_sel, 2'b10);
    bus.inc_btn = 1'b0; step();

    // Timeout from SET_SEC.
    do_reset();
    set_cur(1, 2, 3);
    press_mode(); press_mode(); press_mode();
    load_seen = 0;
    repeat (TO - 1) do_tick();
    check("to_not_yet", bus.edit_active, 1'b1);
    do_tick();
    check("to_edit_active", bus.edit_active, 1'b0);
    check("to_field_sel", bus.field_sel, 2'b00);
    check("to_set_hold", {bus.set_hr, bus.set_min, bus.set_sec}, {5'd1, 6'd2, 6'd3});
    check("to_no_load", load_seen, 1'b0);

    // mode + inc edge in SET_HR, then timeout coincident with mode in SET_MIN.
    do_reset();
    set_cur(5, 0, 0);
    press_mode();
    drive(1, 1, 0); step();
    check("sim_field", bus.field_sel, 2'b10);
    check("sim_hr", bus.set_hr, 5);
    drive(0, 0, 0); step();
    repeat (TO - 1) do_tick();
    drive(1, 0, 1); step();
    drive(0, 0, 0);
    check("to_vs_mode", bus.field_sel, 2'b11);

    // Reset in SET_MIN.
    do_reset();
    set_cur(9, 9, 9);
    press_mode(); press_mode();
    load_seen = 0;
    rst = 1'b1; step();
    check("rst_mid_edit", dut_out(), 24'h0);
    rst = 1'b0; step();
    check("rst_stays_normal", dut_out(), 24'h0);
    check("rst_no_load", load_seen, 1'b0);

    // Randomized run against the model.
    do_reset();
    gap = 0;
    for (int c = 0; c < 4000; c++) begin
      bus.mode_btn = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 31) == 0) bus.inc_btn = ~bus.inc_btn;
      gap++;
      bus.tick = 1'b0;
      if (gap >= 3 && $urandom_range(0, 1) == 1) begin
        bus.tick = 1'b1;
        gap = 0;
      end
      if ($urandom_range(0, 15) == 0)
        set_cur($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0;
    drive(0, 0, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
